// File: rtl/edge_gen.sv
// Edge/level generator: converts rise/fall/toggle commands into a registered level
// with a minimum dwell between transitions, plus one-cycle rise/fall/error strobes.
module edge_gen #(
   parameter int   HOLD_W   = 8,
   parameter int   MIN_HOLD = 4,
   parameter logic INIT_LVL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   output logic       cmd_ready,
   output logic       dout,
   output logic       rise_o,
   output logic       fall_o,
   output logic       err_o,
   output logic       busy
);

   generate
      if (MIN_HOLD < 1 || MIN_HOLD >= (1 << HOLD_W)) begin : g_bad_min_hold
         $error("edge_gen: MIN_HOLD must lie in 1..2**HOLD_W-1");
      end
   endgenerate

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_RISE   = 2'b01;
   localparam logic [1:0] OP_FALL   = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
   localparam logic              USE_HOLD  = (MIN_HOLD > 1);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [HOLD_W-1:0]  cnt_q, cnt_d;
   logic               dout_q, dout_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic               err_q, err_d;
   logic               accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= INIT_LVL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         err_q   <= err_d;
      end
   end

   assign accept = cmd_valid && (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      err_d   = 1'b0;
      if (state_q == HOLD) begin
         // Dwell countdown; leaving on the 1->0 edge makes the next change land at E0+MIN_HOLD.
         if (cnt_q <= HOLD_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q - HOLD_W'(1);
         end
      end else if (accept) begin
         if ((cmd_op == OP_TOGGLE) ||
             (cmd_op == OP_RISE && !dout_q) ||
             (cmd_op == OP_FALL &&  dout_q)) begin
            dout_d  = !dout_q;
            rise_d  = !dout_q;
            fall_d  = dout_q;
            cnt_d   = HOLD_LOAD;
            state_d = USE_HOLD ? HOLD : IDLE;
         end else if (cmd_op != OP_NOP) begin
            err_d = 1'b1;
         end
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == HOLD);
   assign dout      = dout_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen: one MIN_HOLD=4 instance and one MIN_HOLD=1 instance.
module tb_edge_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic       cmd_ready, dout, rise_o, fall_o, err_o, busy;
   logic       cmd_valid1 = 1'b0;
   logic [1:0] cmd_op1 = 2'b00;
   logic       cmd_ready1, dout1, rise1, fall1, err1, busy1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   edge_gen #(.HOLD_W(8), .MIN_HOLD(4), .INIT_LVL(1'b0)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .dout(dout), .rise_o(rise_o), .fall_o(fall_o),
      .err_o(err_o), .busy(busy)
   );

   edge_gen #(.HOLD_W(8), .MIN_HOLD(1), .INIT_LVL(1'b0)) dut1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_op(cmd_op1),
      .cmd_ready(cmd_ready1), .dout(dout1), .rise_o(rise1), .fall_o(fall1),
      .err_o(err1), .busy(busy1)
   );

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      total++;
      if ({dout, rise_o, fall_o, err_o, cmd_ready, busy} !== 6'b000010) begin
         bad++;
         $display("FAIL reset_state got=%b want=000010", {dout, rise_o, fall_o, err_o, cmd_ready, busy});
      end
      rst = 1'b1;
      step();
      $display("reset: dout=%b ready=%b busy=%b", dout, cmd_ready, busy);
   endtask

   task automatic test_rise();
      logic [2:0] got;
      cmd_valid = 1'b1; cmd_op = 2'b01;
      step();
      cmd_valid = 1'b0; cmd_op = 2'b00;
      total++;
      if ({dout, rise_o, fall_o, err_o, cmd_ready, busy} !== 6'b110001) begin
         bad++;
         $display("FAIL rise_e0 got=%b want=110001", {dout, rise_o, fall_o, err_o, cmd_ready, busy});
      end
      for (int i = 0; i < 3; i++) begin
         step();
         got = {rise_o, cmd_ready, busy};
         total++;
         if (got !== ((i == 2) ? 3'b010 : 3'b001)) begin
            bad++;
            $display("FAIL rise_hold_%0d got=%b want=%b", i, got, (i == 2) ? 3'b010 : 3'b001);
         end
      end
      $display("rise: dout=%b ready=%b", dout, cmd_ready);
   endtask

   task automatic test_redundant();
      cmd_valid = 1'b1; cmd_op = 2'b01;
      step();
      cmd_valid = 1'b0; cmd_op = 2'b00;
      total++;
      if ({dout, rise_o, fall_o, err_o, cmd_ready, busy} !== 6'b100110) begin
         bad++;
         $display("FAIL redundant_rise got=%b want=100110", {dout, rise_o, fall_o, err_o, cmd_ready, busy});
      end
      step();
      total++;
      if (err_o !== 1'b0) begin
         bad++;
         $display("FAIL redundant_err_clear got=%b want=0", err_o);
      end
      $display("redundant: dout=%b err cleared=%b", dout, ~err_o);
   endtask

   task automatic test_nop();
      cmd_valid = 1'b1; cmd_op = 2'b00;
      step();
      cmd_valid = 1'b0;
      total++;
      if ({dout, rise_o, fall_o, err_o, cmd_ready, busy} !== 6'b100010) begin
         bad++;
         $display("FAIL nop got=%b want=100010", {dout, rise_o, fall_o, err_o, cmd_ready, busy});
      end
      $display("nop: dout=%b", dout);
   endtask

   task automatic test_toggle();
      logic exp_dout;
      logic flip;
      exp_dout = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b11;
      for (int i = 0; i < 16; i++) begin
         step();
         flip = (i % 4 == 0);
         if (flip) exp_dout = ~exp_dout;
         total++;
         if ({dout, rise_o, fall_o, cmd_ready} !== {exp_dout, flip & exp_dout, flip & ~exp_dout, (i % 4 == 3)}) begin
            bad++;
            $display("FAIL toggle_%0d got=%b want=%b", i, {dout, rise_o, fall_o, cmd_ready},
                     {exp_dout, flip & exp_dout, flip & ~exp_dout, (i % 4 == 3)});
         end
      end
      cmd_valid = 1'b0; cmd_op = 2'b00;
      $display("toggle: dout=%b", dout);
   endtask

   task automatic test_back_to_back();
      // dout is 1 and idle: toggle low, wait out the dwell, rise, then offer fall while busy.
      cmd_valid = 1'b1; cmd_op = 2'b11;
      step();
      cmd_valid = 1'b0;
      repeat (3) step();
      cmd_valid = 1'b1; cmd_op = 2'b01;
      step();
      total++;
      if ({dout, rise_o} !== 2'b11) begin
         bad++;
         $display("FAIL b2b_rise got=%b want=11", {dout, rise_o});
      end
      cmd_op = 2'b10;
      for (int i = 1; i <= 4; i++) begin
         step();
         total++;
         if ({dout, fall_o} !== ((i == 4) ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL b2b_fall_%0d got=%b want=%b", i, {dout, fall_o}, (i == 4) ? 2'b01 : 2'b10);
         end
      end
      cmd_valid = 1'b0; cmd_op = 2'b00;
      $display("back_to_back: dout=%b busy=%b", dout, busy);
   endtask

   task automatic test_reset_mid_hold();
      repeat (4) step();
      cmd_valid = 1'b1; cmd_op = 2'b01;
      step();
      cmd_valid = 1'b0; cmd_op = 2'b00;
      step();
      step();
      total++;
      if ({dout, busy} !== 2'b11) begin
         bad++;
         $display("FAIL midhold_pre got=%b want=11", {dout, busy});
      end
      rst = 1'b0;
      #1;
      total++;
      if ({dout, rise_o, fall_o, err_o} !== 4'b0000) begin
         bad++;
         $display("FAIL midhold_async got=%b want=0000", {dout, rise_o, fall_o, err_o});
      end
      step();
      rst = 1'b1;
      step();
      total++;
      if ({dout, fall_o, cmd_ready, busy} !== 4'b0010) begin
         bad++;
         $display("FAIL midhold_release got=%b want=0010", {dout, fall_o, cmd_ready, busy});
      end
      $display("reset_mid_hold: dout=%b ready=%b", dout, cmd_ready);
   endtask

   task automatic test_min_hold1();
      logic exp_dout;
      exp_dout = 1'b0;
      cmd_valid1 = 1'b1; cmd_op1 = 2'b11;
      for (int i = 0; i < 8; i++) begin
         step();
         exp_dout = ~exp_dout;
         total++;
         if ({dout1, rise1, fall1, cmd_ready1, busy1} !== {exp_dout, exp_dout, ~exp_dout, 2'b10}) begin
            bad++;
            $display("FAIL minhold1_%0d got=%b want=%b", i, {dout1, rise1, fall1, cmd_ready1, busy1},
                     {exp_dout, exp_dout, ~exp_dout, 2'b10});
         end
      end
      cmd_valid1 = 1'b0; cmd_op1 = 2'b00;
      $display("min_hold1: dout1=%b", dout1);
   endtask

   initial begin
      #2;
      test_reset();
      test_rise();
      test_redundant();
      test_nop();
      test_toggle();
      test_back_to_back();
      test_reset_mid_hold();
      test_min_hold1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
